huffman_tree_ctrl: RTL and testbench

- Sequential controller that builds a Huffman code for 8 symbols around the combinational 8-way weight sorter.
- Loads 8 symbol weights serially, then runs 7 merge iterations. Each iteration drives the sorter's character/weight buses and consumes its sorted character bus.
- Tracks per-symbol code bits and lengths, then streams the final code table out, one symbol per cycle.
- Sits directly upstream of the sorter (feeds it) and downstream of it (consumes its result).

---
 rtl/huffman_tree_ctrl.sv | 177 +++++++++++++++++
 tb/tb_huffman_tree_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_tree_ctrl.sv
// Huffman code builder for 8 symbols: serial weight load, 7 merge rounds through an
// external stable 8-way weight sorter, then a one-symbol-per-cycle code table stream.
module huffman_tree_ctrl #(
  parameter int N_SYM  = 8,
  parameter int W_W    = 5,
  parameter int CODE_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [W_W-1:0]       in_weight,
  output logic [4*N_SYM-1:0]   sort_char_o,
  output logic [W_W*N_SYM-1:0] sort_weight_o,
  input  logic [4*N_SYM-1:0]   sort_char_i,
  output logic                 busy,
  output logic                 out_valid,
  output logic [2:0]           out_sym,
  output logic [2:0]           out_len,
  output logic [CODE_W-1:0]    out_code
);

  localparam int N_NODE = 2*N_SYM - 1;

  typedef enum logic [1:0] {IDLE, LOAD, MERGE, OUT} state_t;
  state_t state, state_nxt;

  logic [2:0]        ld_cnt;
  logic [2:0]        iter;
  logic [3:0]        n_act;
  logic [3:0]        slot          [N_SYM];
  logic [3:0]        slot_nxt      [N_SYM];
  logic [W_W-1:0]    node_w        [N_NODE];
  logic [N_SYM-1:0]  node_m        [N_SYM-1];
  logic [CODE_W-1:0] leaf_code     [N_SYM];
  logic [CODE_W-1:0] leaf_code_nxt [N_SYM];
  logic [2:0]        leaf_len      [N_SYM];
  logic [2:0]        leaf_len_nxt  [N_SYM];
  logic [3:0]        id_a, id_b, id_new;
  logic [W_W-1:0]    w_a, w_b, w_new;
  logic [N_SYM-1:0]  m_a, m_b;
  logic [2:0]        app_pos;

  // Iteration i (0-based) creates node 8+i; the active slot count shrinks by one per round.
  assign n_act   = 4'd8 - {1'b0, iter};
  assign id_a    = sort_char_i[3:0];
  assign id_b    = sort_char_i[7:4];
  assign id_new  = {1'b1, iter};
  assign app_pos = 3'd6 - iter;
  assign w_new   = w_a + w_b;

  always_comb begin
    w_a = '1;
    w_b = '1;
    m_a = '0;
    m_b = '0;
    if (id_a != 4'hF) w_a = node_w[id_a];
    if (id_b != 4'hF) w_b = node_w[id_b];
    // Leaf masks are implicit one-hots; only internal nodes keep a mask register.
    if (!id_a[3])            m_a[id_a[2:0]] = 1'b1;
    else if (id_a != 4'hF)   m_a = node_m[id_a[2:0]];
    if (!id_b[3])            m_b[id_b[2:0]] = 1'b1;
    else if (id_b != 4'hF)   m_b = node_m[id_b[2:0]];
  end

  always_comb begin
    for (int unsigned l = 0; l < N_SYM; l++) begin
      leaf_code_nxt[l] = leaf_code[l];
      leaf_len_nxt[l]  = leaf_len[l];
      if ((m_a[l] || m_b[l]) && leaf_len[l] != 3'd7) begin
        leaf_code_nxt[l][leaf_len[l]] = m_b[l];
        leaf_len_nxt[l]               = leaf_len[l] + 3'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_SYM; k++) slot_nxt[k] = 4'hF;
    for (int unsigned k = 0; k < N_SYM-2; k++) begin
      if (k + 2 < 32'(n_act)) slot_nxt[k] = sort_char_i[4*(k+2) +: 4];
    end
    slot_nxt[app_pos] = id_new;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                      state_nxt = LOAD;
      LOAD:    if (in_valid && ld_cnt == 3'd7)    state_nxt = MERGE;
      MERGE:   if (iter == 3'd6)                  state_nxt = OUT;
      OUT:     if (out_sym == 3'd7)               state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    sort_char_o   = '0;
    sort_weight_o = '0;
    if (state == MERGE) begin
      for (int unsigned k = 0; k < N_SYM; k++) begin
        if (k < 32'(n_act)) begin
          sort_char_o[4*k +: 4]       = slot[k];
          sort_weight_o[W_W*k +: W_W] = node_w[slot[k]];
        end else begin
          sort_char_o[4*k +: 4]       = 4'hF;
          sort_weight_o[W_W*k +: W_W] = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt    <= '0;
      iter      <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_len   <= '0;
      out_code  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          node_w[0] <= in_weight;
          ld_cnt    <= 3'd1;
          for (int unsigned l = 0; l < N_SYM; l++) begin
            leaf_code[l] <= '0;
            leaf_len[l]  <= '0;
          end
        end
        LOAD: if (in_valid) begin
          node_w[{1'b0, ld_cnt}] <= in_weight;
          ld_cnt                 <= ld_cnt + 3'd1;
          if (ld_cnt == 3'd7) begin
            iter <= '0;
            for (int unsigned k = 0; k < N_SYM; k++) slot[k] <= 4'(k);
          end
        end
        MERGE: begin
          for (int unsigned k = 0; k < N_SYM; k++) slot[k] <= slot_nxt[k];
          for (int unsigned l = 0; l < N_SYM; l++) begin
            leaf_code[l] <= leaf_code_nxt[l];
            leaf_len[l]  <= leaf_len_nxt[l];
          end
          node_w[id_new] <= w_new;
          node_m[iter]   <= m_a | m_b;
          iter           <= iter + 3'd1;
          // Symbol 0 is presented straight off the final merge so the table starts without a bubble.
          if (iter == 3'd6) begin
            out_valid <= 1'b1;
            out_sym   <= '0;
            out_len   <= leaf_len_nxt[0];
            out_code  <= leaf_code_nxt[0];
          end
        end
        OUT: begin
          if (out_sym == 3'd7) begin
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_len   <= '0;
            out_code  <= '0;
          end else begin
            out_sym  <= out_sym + 3'd1;
            out_len  <= leaf_len[out_sym + 3'd1];
            out_code <= leaf_code[out_sym + 3'd1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_tree_ctrl.sv
// Bench for huffman_tree_ctrl: behavioural stable sorter plus a queue-based Huffman reference.
module tb_huffman_tree_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_weight;
  logic [31:0] sort_char_o;
  logic [39:0] sort_weight_o;
  logic [31:0] sort_char_i;
  logic        busy;
  logic        out_valid;
  logic [2:0]  out_sym;
  logic [2:0]  out_len;
  logic [6:0]  out_code;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         wt;
    logic [7:0] m;
  } node_t;

  huffman_tree_ctrl #(.N_SYM(8), .W_W(5), .CODE_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_weight     (in_weight),
    .sort_char_o   (sort_char_o),
    .sort_weight_o (sort_weight_o),
    .sort_char_i   (sort_char_i),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_sym       (out_sym),
    .out_len       (out_len),
    .out_code      (out_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stable sort by weight: output position = number of slots that must precede this one.
  int rk [8];
  always_comb begin
    sort_char_i = '0;
    for (int k = 0; k < 8; k++) begin
      rk[k] = 0;
      for (int j = 0; j < 8; j++) begin
        if (sort_weight_o[5*j +: 5] < sort_weight_o[5*k +: 5] ||
            (sort_weight_o[5*j +: 5] == sort_weight_o[5*k +: 5] && j < k))
          rk[k] = rk[k] + 1;
      end
      sort_char_i[4*rk[k] +: 4] = sort_char_o[4*k +: 4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_table(input logic [4:0] w [8],
                                    output logic [6:0] code [8],
                                    output logic [2:0] len [8]);
    node_t q[$];
    node_t a, b, key;
    int    ln [8];
    int    j;
    for (int i = 0; i < 8; i++) begin
      q.push_back('{int'(w[i]), 8'(1 << i)});
      code[i] = '0;
      ln[i]   = 0;
    end
    repeat (7) begin
      for (int i = 1; i < q.size(); i++) begin
        key = q[i];
        j   = i - 1;
        while (j >= 0 && q[j].wt > key.wt) begin
          q[j+1] = q[j];
          j--;
        end
        q[j+1] = key;
      end
      a = q[0];
      b = q[1];
      q.delete(0);
      q.delete(0);
      for (int l = 0; l < 8; l++) begin
        if (a.m[l] && ln[l] < 7) begin code[l][ln[l]] = 1'b0; ln[l]++; end
        if (b.m[l] && ln[l] < 7) begin code[l][ln[l]] = 1'b1; ln[l]++; end
      end
      q.push_back('{(a.wt + b.wt) % 32, a.m | b.m});
    end
    for (int l = 0; l < 8; l++) len[l] = 3'(ln[l]);
  endfunction

  task automatic drive_load(input logic [4:0] w [8], input int gap_at, input int gap_len);
    check("busy_before_load", 32'(busy), 32'(0));
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid  = 1'b1;
      in_weight = w[i];
      @(posedge clk); #1;
      if (i == 0) check("busy_after_first_beat", 32'(busy), 32'(1));
    end
    in_valid = 1'b0;
  endtask

  // Starts in cycle T+1 (just after the last beat's edge) and ends mid-cycle T+16.
  task automatic check_table(input logic [4:0] w [8], input bit noise, input bit chk_codes);
    logic [6:0] rc [8];
    logic [2:0] rl [8];
    bit         ov_exp;
    int         s;
    ref_table(w, rc, rl);
    in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      ov_exp = (c >= 8 && c <= 15);
      check($sformatf("out_valid_c%0d", c), 32'(out_valid), 32'(ov_exp));
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 15));
      if (ov_exp) begin
        s = c - 8;
        check($sformatf("out_sym_c%0d", c), 32'(out_sym), 32'(s));
        if (chk_codes) begin
          check($sformatf("out_len_sym%0d", s), 32'(out_len), 32'(rl[s]));
          check($sformatf("out_code_sym%0d", s), 32'(out_code), 32'(rc[s]));
        end
      end else begin
        check($sformatf("out_len_idle_c%0d", c), 32'(out_len), 32'(0));
        check($sformatf("out_code_idle_c%0d", c), 32'(out_code), 32'(0));
      end
      if (c < 16) begin
        @(posedge clk); #1;
        in_valid  = (noise && c < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_weight = 5'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic void rand_weights(output logic [4:0] w [8]);
    int rem = 31;
    int v;
    for (int i = 0; i < 8; i++) begin
      v    = $urandom_range(0, (rem < 9) ? rem : 9);
      w[i] = 5'(v);
      rem -= v;
    end
  endfunction

  logic [4:0] w_two  [8];
  logic [4:0] w_skew [8];
  logic [4:0] w_zero [8];
  logic [4:0] w_big  [8];
  logic [4:0] w_rnd  [8];

  initial begin
    w_two  = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    w_skew = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd20};
    w_zero = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    w_big  = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_weight = '0;
    idle(2);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sym", 32'(out_sym), 32'(0));
    check("rst_out_len", 32'(out_len), 32'(0));
    check("rst_out_code", 32'(out_code), 32'(0));
    check("rst_sort_char", sort_char_o, 32'(0));
    check("rst_sort_weight", 32'(sort_weight_o[39:32] | sort_weight_o[31:0]), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    drive_load(w_two, -1, 0);
    check_table(w_two, 1'b0, 1'b1);
    idle(2);

    drive_load(w_skew, -1, 0);
    check_table(w_skew, 1'b0, 1'b1);
    idle(3);

    // Abort in the middle of the merge rounds, then reload from scratch.
    drive_load(w_two, -1, 0);
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_sort_char", sort_char_o, 32'(0));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_c%0d", c), 32'(out_valid | busy), 32'(0));
    end
    drive_load(w_two, -1, 0);
    check_table(w_two, 1'b0, 1'b1);
    idle(2);

    drive_load(w_skew, 5, 3);
    check_table(w_skew, 1'b1, 1'b1);
    idle(2);

    drive_load(w_zero, -1, 0);
    check_table(w_zero, 1'b0, 1'b1);

    // Second load begins in the cycle right after the last table beat.
    drive_load(w_two, -1, 0);
    check_table(w_two, 1'b0, 1'b1);
    drive_load(w_skew, -1, 0);
    check_table(w_skew, 1'b0, 1'b1);
    idle(1);

    for (int r = 0; r < 10; r++) begin
      rand_weights(w_rnd);
      drive_load(w_rnd, (r % 3 == 0) ? int'($urandom_range(1, 7)) : -1, int'($urandom_range(1, 4)));
      check_table(w_rnd, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    // Over-range weights: only the framing of the table is defined.
    drive_load(w_big, -1, 0);
    check_table(w_big, 1'b0, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
